// File: rtl/alu_ctrl.sv
// Issue-side controller for the combinational alu: accepts an instruction,
// reads two operands from a small register file, drives the alu, writes the
// result back and returns it with locally completed {V,N,Z} flags.
module alu_ctrl #(
  parameter int unsigned BW       = 8,
  parameter int unsigned RegAddrW = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      instr_valid_i,
  input  logic [3+3*RegAddrW-1:0]   instr_i,
  output logic                      instr_ready_o,
  input  logic                      ld_en_i,
  input  logic [RegAddrW-1:0]       ld_addr_i,
  input  logic [BW-1:0]             ld_data_i,
  output logic [BW-1:0]             alu_a_o,
  output logic [BW-1:0]             alu_b_o,
  output logic [2:0]                alu_op_o,
  input  logic [BW-1:0]             alu_out_i,
  input  logic [2:0]                alu_flags_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [BW-1:0]             res_data_o,
  output logic [2:0]                res_flags_o,
  input  logic                      clr_ovf_i,
  output logic                      ovf_sticky_o
);

  localparam int unsigned InstrW = 3 + 3 * RegAddrW;
  localparam int unsigned Depth  = 2 ** RegAddrW;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic [InstrW-1:0]   instr_q, instr_d;
  logic [BW-1:0]       rf_q [Depth];
  logic [BW-1:0]       rf_d [Depth];
  logic [BW-1:0]       res_data_q, res_data_d;
  logic [2:0]          res_flags_q, res_flags_d;
  logic                ovf_q, ovf_d;

  logic [2:0]          op;
  logic [RegAddrW-1:0] dst, srca, srcb;
  logic                accept, exec;

  // Only the alu overflow bit is consumed; N and Z are recomputed here.
  logic                unused_flags;
  assign unused_flags = ^alu_flags_i[1:0];

  assign op     = instr_q[InstrW-1 -: 3];
  assign dst    = instr_q[3*RegAddrW-1 -: RegAddrW];
  assign srca   = instr_q[2*RegAddrW-1 -: RegAddrW];
  assign srcb   = instr_q[RegAddrW-1:0];
  assign accept = (state_q == StIdle) && instr_valid_i && !rst_i;
  assign exec   = (state_q == StExec);

  // Operands are driven continuously from the latched instruction.
  assign alu_a_o  = rf_q[srca];
  assign alu_b_o  = rf_q[srcb];
  assign alu_op_o = op;

  // State register and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      ovf_q       <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      ovf_q       <= ovf_d;
      for (int unsigned i = 0; i < Depth; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (instr_valid_i) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (res_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    instr_ready_o = (state_q == StIdle) && !rst_i;
    res_valid_o   = (state_q == StResp);
    res_data_o    = res_data_q;
    res_flags_o   = res_flags_q;
    ovf_sticky_o  = ovf_q;
  end

  // Datapath next-state: latch, register file update, result capture, sticky overflow.
  always_comb begin
    instr_d     = accept ? instr_i : instr_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    ovf_d       = ovf_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (ld_en_i) begin
      rf_d[ld_addr_i] = ld_data_i;
    end
    // Writeback is applied after the direct load so it wins on an address clash.
    if (exec) begin
      rf_d[dst]   = alu_out_i;
      res_data_d  = alu_out_i;
      res_flags_d = {alu_flags_i[2], alu_out_i[BW-1], (alu_out_i == '0)};
    end
    if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
    // Set beats clear when both happen together.
    if (exec && alu_flags_i[2]) begin
      ovf_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl (BW=8, RegAddrW=2). A behavioural alu is
// attached to the DUT; expected results are queued on issue and checked on
// each result handshake.
module tb_alu_ctrl;

  localparam logic [2:0] OpAdd = 3'b000, OpSub = 3'b001, OpAnd = 3'b010, OpOr = 3'b011;
  localparam logic [2:0] OpXor = 3'b100, OpInc = 3'b101, OpMova = 3'b110, OpMovb = 3'b111;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       instr_valid_i = 1'b0;
  logic [8:0] instr_i = '0;
  logic       instr_ready_o;
  logic       ld_en_i = 1'b0;
  logic [1:0] ld_addr_i = '0;
  logic [7:0] ld_data_i = '0;
  logic [7:0] alu_a_o, alu_b_o, alu_out_i;
  logic [2:0] alu_op_o, alu_flags_i;
  logic       res_valid_o;
  logic       res_ready_i = 1'b0;
  logic [7:0] res_data_o;
  logic [2:0] res_flags_o;
  logic       clr_ovf_i = 1'b0;
  logic       ovf_sticky_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];   // {V,N,Z,data}
  logic [7:0]  rf_m [4];

  alu_ctrl #(.BW(8), .RegAddrW(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .instr_ready_o(instr_ready_o), .ld_en_i(ld_en_i), .ld_addr_i(ld_addr_i),
    .ld_data_i(ld_data_i), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_out_i(alu_out_i), .alu_flags_i(alu_flags_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_flags_o(res_flags_o),
    .clr_ovf_i(clr_ovf_i), .ovf_sticky_o(ovf_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural alu: returns {V, out}; V is signed overflow of ADD/SUB only.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    logic [7:0] s;
    logic       v;
    v = 1'b0;
    case (op)
      OpAdd:   begin s = a + b; v = (a[7] == b[7]) && (s[7] != a[7]); end
      OpSub:   begin s = a - b; v = (a[7] != b[7]) && (s[7] != a[7]); end
      OpAnd:   s = a & b;
      OpOr:    s = a | b;
      OpXor:   s = a ^ b;
      OpInc:   s = a + 8'd1;
      OpMova:  s = a;
      default: s = b;
    endcase
    return {v, s};
  endfunction

  logic [8:0] alu_r;
  always_comb begin
    alu_r       = alu_f(alu_a_o, alu_b_o, alu_op_o);
    alu_out_i   = alu_r[7:0];
    alu_flags_i = {alu_r[8], alu_r[7], (alu_r[7:0] == 8'h00)};
  end

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_en_i = 1'b1; ld_addr_i = a; ld_data_i = d;
    rf_m[a] = d;
    @(posedge clk_i); #1;
    ld_en_i = 1'b0;
  endtask

  // Queues the expected result and returns 1ns after the accepting edge (EXEC cycle).
  task automatic send(input logic [2:0] op, input logic [1:0] d, input logic [1:0] a,
                      input logic [1:0] b);
    logic [8:0] r;
    int k;
    r = alu_f(rf_m[a], rf_m[b], op);
    exp_q.push_back({r[8], r[7], (r[7:0] == 8'h00), r[7:0]});
    rf_m[d] = r[7:0];
    instr_i = {op, d, a, b};
    instr_valid_i = 1'b1;
    k = 0;
    while (instr_ready_o !== 1'b1 && k < 20) begin @(negedge clk_i); k++; end
    n_cmp++;
    if (k >= 20) begin n_err++; $display("FAIL accept_timeout: ready=%b required 1", instr_ready_o); end
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
  endtask

  // Waits for a result, pops the scoreboard and compares, then completes the handshake.
  task automatic collect(input string nm);
    logic [10:0] e;
    int k;
    res_ready_i = 1'b1;
    k = 0;
    while (res_valid_o !== 1'b1 && k < 20) begin @(negedge clk_i); k++; end
    n_cmp++;
    if (k >= 20 || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_resp: valid=%b queued=%0d required valid=1 with entry", nm, res_valid_o,
               exp_q.size());
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (res_data_o !== e[7:0]) begin
        n_err++; $display("FAIL %s_data: got %h required %h", nm, res_data_o, e[7:0]);
      end
      n_cmp++;
      if (res_flags_o !== e[10:8]) begin
        n_err++; $display("FAIL %s_flags: got %b required %b", nm, res_flags_o, e[10:8]);
      end
    end
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if (instr_ready_o !== 1'b0 || res_valid_o !== 1'b0 || ovf_sticky_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outs: rdy=%b vld=%b ovf=%b required 0 0 0", instr_ready_o,
               res_valid_o, ovf_sticky_o);
    end
    n_cmp++;
    if (res_data_o !== 8'h00 || res_flags_o !== 3'b000) begin
      n_err++; $display("FAIL reset_res: data=%h flags=%b required 00 000", res_data_o, res_flags_o);
    end
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (instr_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b required 1", instr_ready_o);
    end
  endtask

  task automatic test_add;
    load(2'd0, 8'd100);
    load(2'd1, 8'd50);
    send(OpAdd, 2'd2, 2'd0, 2'd1);
    // Accept cycle starts at edge n and completes at n+1; the result shows from edge n+2.
    n_cmp++;
    if (res_valid_o !== 1'b0 || instr_ready_o !== 1'b0) begin
      n_err++; $display("FAIL add_exec_cycle: vld=%b rdy=%b required 0 0", res_valid_o,
                        instr_ready_o);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if (res_valid_o !== 1'b1) begin
      n_err++; $display("FAIL add_latency: vld=%b required 1", res_valid_o);
    end
    collect("add");
    n_cmp++;
    if (ovf_sticky_o !== 1'b1) begin
      n_err++; $display("FAIL add_sticky: got %b required 1", ovf_sticky_o);
    end
    send(OpMova, 2'd3, 2'd2, 2'd2);
    collect("add_rf2");
  endtask

  task automatic test_sub_clr;
    send(OpSub, 2'd3, 2'd1, 2'd1);
    collect("sub");
    n_cmp++;
    if (ovf_sticky_o !== 1'b1) begin
      n_err++; $display("FAIL sub_sticky_held: got %b required 1", ovf_sticky_o);
    end
    clr_ovf_i = 1'b1;
    @(posedge clk_i); #1;
    clr_ovf_i = 1'b0;
    n_cmp++;
    if (ovf_sticky_o !== 1'b0) begin
      n_err++; $display("FAIL clr_ovf: got %b required 0", ovf_sticky_o);
    end
  endtask

  task automatic test_sticky_priority;
    load(2'd0, 8'h70);
    load(2'd1, 8'h70);
    send(OpAdd, 2'd3, 2'd0, 2'd1);
    clr_ovf_i = 1'b1;   // clear in the same cycle as the overflowing capture
    @(posedge clk_i); #1;
    clr_ovf_i = 1'b0;
    n_cmp++;
    if (ovf_sticky_o !== 1'b1) begin
      n_err++; $display("FAIL sticky_set_wins: got %b required 1", ovf_sticky_o);
    end
    collect("sticky_add");
  endtask

  task automatic test_hold;
    logic [10:0] e;
    load(2'd2, 8'h3C);
    send(OpOr, 2'd3, 2'd2, 2'd0);
    @(posedge clk_i); #1;
    e = exp_q[0];
    instr_i = {OpAnd, 2'd0, 2'd0, 2'd0};
    instr_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (res_valid_o !== 1'b1 || instr_ready_o !== 1'b0 || res_data_o !== e[7:0] ||
          res_flags_o !== e[10:8]) begin
        n_err++;
        $display("FAIL hold_c%0d: vld=%b rdy=%b data=%h flags=%b required 1 0 %h %b", c,
                 res_valid_o, instr_ready_o, res_data_o, res_flags_o, e[7:0], e[10:8]);
      end
      @(posedge clk_i); #1;
    end
    instr_valid_i = 1'b0;
    collect("hold");
    n_cmp++;
    if (instr_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
      n_err++; $display("FAIL hold_no_accept: rdy=%b vld=%b required 1 0", instr_ready_o,
                        res_valid_o);
    end
  endtask

  task automatic test_back_to_back;
    load(2'd0, 8'h7F);
    send(OpInc, 2'd0, 2'd0, 2'd0);
    collect("inc");
    send(OpMova, 2'd1, 2'd0, 2'd0);
    collect("mova");
    send(OpMovb, 2'd3, 2'd2, 2'd1);
    collect("movb_rf1");
  endtask

  task automatic test_ld_accept;
    ld_en_i = 1'b1; ld_addr_i = 2'd0; ld_data_i = 8'h11;
    rf_m[0] = 8'h11;
    send(OpAdd, 2'd1, 2'd0, 2'd0);
    ld_en_i = 1'b0;
    collect("ld_accept");
  endtask

  task automatic test_ld_collision;
    load(2'd0, 8'hF0);
    load(2'd1, 8'h0F);
    send(OpXor, 2'd2, 2'd0, 2'd1);
    ld_en_i = 1'b1; ld_addr_i = 2'd2; ld_data_i = 8'h55;   // loses to writeback
    @(posedge clk_i); #1;
    ld_en_i = 1'b0;
    collect("xor");
    send(OpMova, 2'd3, 2'd2, 2'd2);
    collect("collision_rf2");
  endtask

  task automatic test_reset_resp;
    load(2'd0, 8'h7F);
    load(2'd1, 8'h01);
    send(OpAdd, 2'd2, 2'd0, 2'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    n_cmp++;
    if (res_valid_o !== 1'b0 || instr_ready_o !== 1'b0 || ovf_sticky_o !== 1'b0 ||
        res_data_o !== 8'h00 || res_flags_o !== 3'b000) begin
      n_err++;
      $display("FAIL rst_resp: vld=%b rdy=%b ovf=%b data=%h flags=%b required 0 0 0 00 000",
               res_valid_o, instr_ready_o, ovf_sticky_o, res_data_o, res_flags_o);
    end
    rst_i = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
    #1;
    n_cmp++;
    if (instr_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_resp_ready: got %b required 1", instr_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      send(OpMova, 2'(i), 2'(i), 2'(i));
      collect("rst_rf_zero");
    end
    load(2'd1, 8'h03);
    send(OpAdd, 2'd2, 2'd1, 2'd1);
    collect("post_rst");
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_clr;
    test_sticky_priority;
    test_hold;
    test_back_to_back;
    test_ld_accept;
    test_ld_collision;
    test_reset_resp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
